// File: rtl/gcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gcd_pkg : shared constants and state encoding for the GCD self-test     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package gcd_pkg;

    localparam int unsigned c_width_def    = 8;
    localparam int unsigned c_timeout_def  = 1023;
    // A table entry packs {a, b, exp}, a in the most significant field.
    localparam int unsigned c_entry_fields = 3;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_load  = 3'd1;
    localparam state_t c_st_issue = 3'd2;
    localparam state_t c_st_wait  = 3'd3;
    localparam state_t c_st_check = 3'd4;
    localparam state_t c_st_done  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/gcd_vec_rom.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gcd_vec_rom : fixed GCD test vector table, {a, b, exp} per index       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module gcd_vec_rom
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = c_width_def,
    parameter int unsigned NUM_VEC = 8
) (
    input  logic [3:0]                      i_idx,
    output logic [c_entry_fields*WIDTH-1:0] o_entry
);

    function automatic logic [c_entry_fields*WIDTH-1:0] pack(input int unsigned a,
                                                             input int unsigned b,
                                                             input int unsigned e);
        return {WIDTH'(a), WIDTH'(b), WIDTH'(e)};
    endfunction

    always_comb begin
        o_entry = '0;
        // Entries beyond the configured table depth read as all zeros.
        if (32'(i_idx) < NUM_VEC) begin
            case (i_idx)
                4'd0:    o_entry = pack(10, 5, 5);
                4'd1:    o_entry = pack(12, 8, 4);
                4'd2:    o_entry = pack(48, 18, 6);
                4'd3:    o_entry = pack(17, 13, 1);
                4'd4:    o_entry = pack(0, 7, 7);
                4'd5:    o_entry = pack(7, 0, 7);
                4'd6:    o_entry = pack(255, 255, 255);
                4'd7:    o_entry = pack(1, 1, 1);
                default: o_entry = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_selftest_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gcd_selftest_driver : walks the vector table through a GCD core and    |
// | reports progress / pass-fail on LED[9:0]                               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module gcd_selftest_driver
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = c_width_def,
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned TIMEOUT = c_timeout_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             gcd_start,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy,
    output logic [9:0]       LED
);

    state_t                           r_state;
    logic                             r_run_q;
    logic [3:0]                       r_idx;
    logic [3:0]                       r_err;
    logic                             r_fail;
    logic                             r_done;
    logic [9:0]                       r_cnt;
    logic                             r_tmo;
    logic [WIDTH-1:0]                 r_exp;
    logic [WIDTH-1:0]                 r_res;
    logic [c_entry_fields*WIDTH-1:0]  w_entry;
    logic                             w_edge;
    logic                             w_mismatch;

    gcd_vec_rom #(
        .WIDTH   (WIDTH),
        .NUM_VEC (NUM_VEC)
    ) u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_edge     = run & ~r_run_q;
    assign w_mismatch = r_tmo | (r_res != r_exp);
    assign LED        = {r_fail, r_done, r_idx, r_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_run_q   <= 1'b0;
            r_idx     <= '0;
            r_err     <= '0;
            r_fail    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
            r_exp     <= '0;
            r_res     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gcd_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_run_q   <= run;
            gcd_start <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_edge) begin
                        r_idx   <= '0;
                        r_err   <= '0;
                        r_fail  <= 1'b0;
                        r_done  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    op_a    <= w_entry[c_entry_fields*WIDTH-1 -: WIDTH];
                    op_b    <= w_entry[2*WIDTH-1 -: WIDTH];
                    r_exp   <= w_entry[WIDTH-1:0];
                    r_state <= c_st_issue;
                end
                c_st_issue: begin
                    gcd_start <= 1'b1;
                    r_cnt     <= '0;
                    r_tmo     <= 1'b0;
                    r_state   <= c_st_wait;
                end
                c_st_wait: begin
                    // A done arriving on the final timeout cycle still wins.
                    if (gcd_done) begin
                        r_res   <= gcd_result;
                        r_state <= c_st_check;
                    end else if (r_cnt == 10'(TIMEOUT - 1)) begin
                        r_tmo   <= 1'b1;
                        r_state <= c_st_check;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                c_st_check: begin
                    if (w_mismatch) begin
                        r_fail <= 1'b1;
                        if (r_err != 4'hF) r_err <= r_err + 4'd1;
                    end
                    if (r_idx == 4'(NUM_VEC - 1)) begin
                        r_done  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_st_done;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= c_st_load;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_selftest_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gcd_selftest_driver : self-checking bench with a behavioural core   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_gcd_selftest_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] op_a, op_b;
    logic       gcd_start;
    logic       gcd_done;
    logic [7:0] gcd_result;
    logic       busy;
    logic [9:0] LED;

    logic       m_done, inj_done;
    logic [7:0] m_res, inj_res;
    int         m_cnt;

    assign gcd_done   = m_done | inj_done;
    assign gcd_result = inj_done ? inj_res : m_res;

    gcd_selftest_driver #(.WIDTH(8), .NUM_VEC(8), .TIMEOUT(1023)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .op_a       (op_a),
        .op_b       (op_b),
        .gcd_start  (gcd_start),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .busy       (busy),
        .LED        (LED)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e;
    } vec_t;

    typedef struct packed {
        logic [7:0] corrupt_mask;
        logic [7:0] corrupt_val;
        logic [7:0] hang_mask;
        logic [9:0] exp_led;
    } scen_t;

    vec_t       tbl [8];
    scen_t      scen [4];
    logic       corrupt [8];
    logic [7:0] cval [8];
    logic       hang [8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] st_a [$];
    logic [7:0] st_b [$];
    int         st_t [$];

    function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int find_vec(input logic [7:0] a, input logic [7:0] b);
        for (int v = 0; v < 8; v++)
            if (tbl[v].a == a && tbl[v].b == b) return v;
        return -1;
    endfunction

    // Expected LED after a full pass, from the core's configured misbehaviour.
    function automatic logic [9:0] exp_led();
        int e = 0;
        int unsigned r;
        for (int v = 0; v < 8; v++) begin
            r = corrupt[v] ? int'(cval[v]) : gcd_ref(tbl[v].a, tbl[v].b);
            if (hang[v] || r != int'(tbl[v].e)) e++;
        end
        return {e > 0, 1'b1, 4'd7, 4'((e > 15) ? 15 : e)};
    endfunction

    // Behavioural GCD core: answers 5 cycles after start unless told to hang.
    always @(posedge clk) begin
        int v;
        cyc <= cyc + 1;
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= 8'd0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_done <= 1'b1;
            end
            if (gcd_start) begin
                v = find_vec(op_a, op_b);
                if (v >= 0 && hang[v]) begin
                    m_cnt <= 0;
                end else begin
                    m_cnt <= 5;
                    m_res <= (v >= 0 && corrupt[v]) ? cval[v] : 8'(gcd_ref(op_a, op_b));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (gcd_start) begin
            st_a.push_back(op_a);
            st_b.push_back(op_b);
            st_t.push_back(cyc);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_core(input logic [7:0] cm, input logic [7:0] cv, input logic [7:0] hm);
        for (int v = 0; v < 8; v++) begin
            corrupt[v] = cm[v];
            cval[v]    = cv;
            hang[v]    = hm[v];
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({nm, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic check_ops(input string nm, input int base);
        check({nm, "_nstart"}, 32'(st_a.size() - base), 32'd8);
        for (int v = 0; v < 8 && base + v < st_a.size(); v++) begin
            check({nm, "_opa"}, 32'(st_a[base + v]), 32'(tbl[v].a));
            check({nm, "_opb"}, 32'(st_b[base + v]), 32'(tbl[v].b));
        end
    endtask

    initial begin
        int base;
        logic [9:0] led_hold;

        tbl[0] = '{8'd10, 8'd5, 8'd5};     tbl[1] = '{8'd12, 8'd8, 8'd4};
        tbl[2] = '{8'd48, 8'd18, 8'd6};    tbl[3] = '{8'd17, 8'd13, 8'd1};
        tbl[4] = '{8'd0, 8'd7, 8'd7};      tbl[5] = '{8'd7, 8'd0, 8'd7};
        tbl[6] = '{8'd255, 8'd255, 8'd255}; tbl[7] = '{8'd1, 8'd1, 8'd1};
        scen[0] = '{8'h00, 8'd0, 8'h00, 10'b01_0111_0000};
        scen[1] = '{8'h02, 8'd3, 8'h00, 10'b11_0111_0001};
        scen[2] = '{8'h00, 8'd0, 8'h10, 10'b11_0111_0001};
        scen[3] = '{8'h81, 8'd9, 8'h04, 10'b11_0111_0011};

        set_core(8'h00, 8'd0, 8'h00);
        rst = 1'b1; run = 1'b0; inj_done = 1'b0; inj_res = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_led", 32'(LED), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ops", {16'd0, op_a, op_b}, 32'd0);

        // Spurious done while idle.
        inj_res = 8'd5; inj_done = 1'b1;
        @(negedge clk) inj_done = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_done_led", 32'(LED), 32'd0);
        check("idle_done_start", 32'(st_a.size()), 32'd0);

        // Start latency: gcd_start seen 3 edges after run rises.
        base = st_a.size();
        run = 1'b1;
        @(negedge clk) check("lat_c1", {busy, gcd_start}, 32'b10);
        run = 1'b0;
        @(negedge clk) check("lat_c2", 32'(gcd_start), 32'd0);
        @(negedge clk) check("lat_c3", 32'(gcd_start), 32'd1);
        wait_idle("first");
        check_ops("first", base);
        check("first_led", 32'(LED), 32'h170);

        for (int s = 0; s < 4; s++) begin
            set_core(scen[s].corrupt_mask, scen[s].corrupt_val, scen[s].hang_mask);
            base = st_a.size();
            pulse_run();
            wait_idle("scen");
            check_ops("scen", base);
            check("scen_led", 32'(LED), 32'(scen[s].exp_led));
            for (int v = 0; v < 7; v++)
                if (scen[s].hang_mask[v] && base + v + 1 < st_t.size())
                    check("timeout_gap", 32'(st_t[base + v + 1] - st_t[base + v]), 32'd1026);
        end

        // Spurious done while in DONE: LED must hold.
        led_hold = LED;
        inj_res = 8'd1; inj_done = 1'b1;
        @(negedge clk) inj_done = 1'b0;
        repeat (5) @(negedge clk);
        check("done_spurious_led", 32'(LED), 32'(led_hold));

        // Re-trigger while busy, then hold run high through DONE.
        set_core(8'h08, 8'd2, 8'h00);
        base = st_a.size();
        pulse_run();
        repeat (20) @(negedge clk);
        run = 1'b1;
        wait_idle("hold");
        repeat (30) @(negedge clk);
        check("hold_nstart", 32'(st_a.size() - base), 32'd8);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_led", 32'(LED), 32'h371);
        set_core(8'h00, 8'd0, 8'h00);
        run = 1'b0;
        @(negedge clk) run = 1'b1;
        @(negedge clk) check("restart_clear", {busy, LED}, {1'b1, 10'd0});
        run = 1'b0;
        wait_idle("restart");
        check("restart_led", 32'(LED), 32'h170);

        // Reset while waiting on vector 3.
        base = st_a.size();
        pulse_run();
        for (int n = 0; n < 200 && st_a.size() < base + 4; n++) @(negedge clk);
        check("rst_reach_v3", 32'(st_a.size() - base), 32'd4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) check("rst_outs", {gcd_start, busy, LED, op_a, op_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        inj_res = 8'd1; inj_done = 1'b1;
        @(negedge clk) inj_done = 1'b0;
        base = st_a.size();
        repeat (10) @(negedge clk);
        check("rst_late_done", {busy, LED}, 32'd0);
        check("rst_no_start", 32'(st_a.size() - base), 32'd0);
        pulse_run();
        wait_idle("after_rst");
        check_ops("after_rst", base);
        check("after_rst_led", 32'(LED), 32'h170);

        // Randomised passes against the reference model.
        for (int p = 0; p < 6; p++) begin
            for (int v = 0; v < 8; v++) begin
                corrupt[v] = ($urandom_range(0, 3) == 0);
                cval[v]    = 8'($urandom_range(0, 255));
                hang[v]    = ($urandom_range(0, 15) == 0);
            end
            base = st_a.size();
            pulse_run();
            wait_idle("rand");
            check("rand_nstart", 32'(st_a.size() - base), 32'd8);
            check("rand_led", 32'(LED), 32'(exp_led()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
